cpu_attack_ctrl: RTL
====================

// Module: cpu_attack_ctrl
// PURPOSE
// - Consumer of the CPU attack-type stream (STANDBY=2'b00, LIGHT=2'b01, HEAVY=2'b10).
// - Samples the type when idle and runs the attack timeline WINDUP -> STRIKE -> COOLDOWN.
// - At strike end, resolves hit versus block against the player's block input.
// - Sits between the CPU type generator and the health/score logic; drives the
//   damage, hit/blocked pulses and attack-state outputs used by the display.
// PARAMETERS
// - CNT_W          8   width of the phase counter
// - LIGHT_WINDUP   4   windup length in ticks, light attack (>=1)
// - HEAVY_WINDUP   8   windup length in ticks, heavy attack (>=1)
// - STRIKE_LEN     2   strike window length in ticks (>=1)
// - LIGHT_COOLDOWN 3   cooldown length in ticks, light attack (>=1)
// - HEAVY_COOLDOWN 6   cooldown length in ticks, heavy attack (>=1)
// - LIGHT_DMG      5   damage for a landed light attack (8-bit)
// - HEAVY_DMG      12  damage for a landed heavy attack (8-bit)
// PORTS
// - i_clk           in   1   clock
// - i_reset         in   1   synchronous, active-high reset
// - i_tick          in   1   game-tick enable; all sampling and counting happen only on tick edges
// - i_enable        in   1   permits sampling a new attack in IDLE
// - i_cpu_type      in   2   attack type from the generator
// - i_player_block  in   1   player is blocking
// - o_state         out  2   0=IDLE 1=WINDUP 2=STRIKE 3=COOLDOWN
// - o_atk_type      out  2   latched type of the attack in progress; 0 in IDLE
// - o_busy          out  1   1 whenever o_state != IDLE
// - o_hit           out  1   one-clock pulse: attack landed
// - o_blocked       out  1   one-clock pulse: attack was blocked
// - o_damage        out  8   damage, valid only while o_hit=1, otherwise 0
// - o_dmg_total     out  16  saturating sum of landed damage
// BEHAVIOUR
// - Reset (synchronous, checked first): all outputs 0, state IDLE, counter 0, block flag 0.
//   Reset aborts an attack in progress; no hit or blocked pulse is emitted.
// - Non-tick edges: state, counter and flag hold; o_hit, o_blocked and o_damage return to 0.
// - IDLE, on a tick with i_enable=1:
//   - LIGHT or HEAVY: latch the type, go to WINDUP, counter = WINDUP(type)-1.
//   - STANDBY or 2'b11: stay in IDLE.
// - i_enable=0: IDLE does not sample; an attack already in progress always completes.
// - WINDUP, on a tick: if counter==0, go to STRIKE with counter = STRIKE_LEN-1 and clear
//   the block flag; otherwise decrement the counter.
// - STRIKE, on every tick including the last: block flag |= i_player_block.
//   - On the last tick (counter==0), go to COOLDOWN. Resolution uses the flag value that
//     includes the current sample.
//   - Not blocked: o_hit=1 and o_damage=DMG(type) for exactly the next cycle;
//     o_dmg_total += DMG, saturating at 16'hFFFF. Counter = COOLDOWN(type)-1.
//   - Blocked: o_blocked=1 for one cycle; no damage. Counter = 2*COOLDOWN(type)-1 (stagger).
// - COOLDOWN, on a tick: if counter==0, go to IDLE and clear o_atk_type; otherwise decrement.
//   The next sample happens on the following tick edge.
// - Width rule: 2*HEAVY_COOLDOWN-1 and every other length minus 1 must fit in CNT_W.
//   Counter arithmetic is unsigned and never wraps in legal use.
// - i_cpu_type changing mid-attack is ignored; only the latched type is used.
// - Timing with i_tick=1 and the sampling edge as E0:
//   - LIGHT: WINDUP E1-E4, STRIKE E5-E6, o_hit after E6, COOLDOWN E7-E9, IDLE after E9.
//   - HEAVY: WINDUP E1-E8, STRIKE E9-E10, o_hit after E10, COOLDOWN E11-E16.
// TESTING
// - i_tick=1, i_enable=1, LIGHT at E0, no block -> o_hit=1, o_damage=5 only in the cycle
//   after E6; IDLE after E9; o_dmg_total=5.
// - HEAVY at E0, i_player_block=1 only at E10 (last strike edge) -> o_blocked pulse after E10,
//   o_hit stays 0, COOLDOWN spans 12 ticks (E11-E22), o_dmg_total unchanged.
// - i_cpu_type=STANDBY or 2'b11 held for 20 cycles -> o_state stays 0, no pulses.
// - i_tick pulsed every 3rd clock with LIGHT -> every phase length scales by 3;
//   o_hit still exactly 1 clock wide.
// - i_reset asserted in the middle of the strike phase -> the next cycle shows all outputs 0,
//   no hit or blocked pulse, o_dmg_total=0.
// - o_dmg_total preloaded near the top (e.g. 65530) plus a HEAVY hit -> o_dmg_total=65535
//   and stays there (saturation).

Source files
------------

// File: rtl/cpu_attack_ctrl_if.sv
// CPU attack controller bus: control/stimulus inputs and display/score outputs.
interface cpu_attack_ctrl_if;
   logic        i_tick;
   logic        i_enable;
   logic [1:0]  i_cpu_type;
   logic        i_player_block;
   logic [1:0]  o_state;
   logic [1:0]  o_atk_type;
   logic        o_busy;
   logic        o_hit;
   logic        o_blocked;
   logic [7:0]  o_damage;
   logic [15:0] o_dmg_total;

   // Side that drives ticks, attack types and block input.
   modport master (
      output i_tick, i_enable, i_cpu_type, i_player_block,
      input  o_state, o_atk_type, o_busy, o_hit, o_blocked, o_damage, o_dmg_total
   );

   // Controller side.
   modport slave (
      input  i_tick, i_enable, i_cpu_type, i_player_block,
      output o_state, o_atk_type, o_busy, o_hit, o_blocked, o_damage, o_dmg_total
   );
endinterface

// File: rtl/cpu_attack_ctrl.sv
// CPU attack timeline: samples an attack type in IDLE, runs WINDUP -> STRIKE -> COOLDOWN,
// resolves hit vs block at strike end and accumulates saturating landed damage.
module cpu_attack_ctrl #(
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned LIGHT_WINDUP   = 4,
   parameter int unsigned HEAVY_WINDUP   = 8,
   parameter int unsigned STRIKE_LEN     = 2,
   parameter int unsigned LIGHT_COOLDOWN = 3,
   parameter int unsigned HEAVY_COOLDOWN = 6,
   parameter int unsigned LIGHT_DMG      = 5,
   parameter int unsigned HEAVY_DMG      = 12
) (
   input  logic               i_clk,
   input  logic               i_reset,
   cpu_attack_ctrl_if.slave   bus
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_WINDUP   = 2'd1;
   localparam logic [1:0] S_STRIKE   = 2'd2;
   localparam logic [1:0] S_COOLDOWN = 2'd3;

   localparam logic [1:0] T_LIGHT = 2'b01;
   localparam logic [1:0] T_HEAVY = 2'b10;

   localparam logic [CNT_W-1:0] LW_M1   = CNT_W'(LIGHT_WINDUP - 1);
   localparam logic [CNT_W-1:0] HW_M1   = CNT_W'(HEAVY_WINDUP - 1);
   localparam logic [CNT_W-1:0] ST_M1   = CNT_W'(STRIKE_LEN - 1);
   localparam logic [CNT_W-1:0] LC_M1   = CNT_W'(LIGHT_COOLDOWN - 1);
   localparam logic [CNT_W-1:0] HC_M1   = CNT_W'(HEAVY_COOLDOWN - 1);
   localparam logic [CNT_W-1:0] LC2_M1  = CNT_W'(2 * LIGHT_COOLDOWN - 1);
   localparam logic [CNT_W-1:0] HC2_M1  = CNT_W'(2 * HEAVY_COOLDOWN - 1);
   localparam logic [7:0]       L_DMG   = 8'(LIGHT_DMG);
   localparam logic [7:0]       H_DMG   = 8'(HEAVY_DMG);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             flag_q, flag_d;
   logic [1:0]       atk_type_q, atk_type_d;
   logic             busy_q, busy_d;
   logic             hit_q, hit_d;
   logic             blocked_q, blocked_d;
   logic [7:0]       damage_q, damage_d;
   logic [15:0]      dmg_total_q, dmg_total_d;

   logic             is_heavy;
   logic             blk_now;
   logic [7:0]       atk_dmg;
   logic [16:0]      dmg_sum;

   // Next-state, counter, resolution and output pulse logic; pulses default low.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      flag_d      = flag_q;
      atk_type_d  = atk_type_q;
      hit_d       = 1'b0;
      blocked_d   = 1'b0;
      damage_d    = 8'd0;
      dmg_total_d = dmg_total_q;

      is_heavy = (atk_type_q == T_HEAVY);
      blk_now  = flag_q | bus.i_player_block;
      atk_dmg  = is_heavy ? H_DMG : L_DMG;
      dmg_sum  = {1'b0, dmg_total_q} + 17'(atk_dmg);

      if (bus.i_tick) begin
         case (state_q)
            S_IDLE: begin
               if (bus.i_enable && (bus.i_cpu_type == T_LIGHT || bus.i_cpu_type == T_HEAVY)) begin
                  atk_type_d = bus.i_cpu_type;
                  state_d    = S_WINDUP;
                  cnt_d      = (bus.i_cpu_type == T_HEAVY) ? HW_M1 : LW_M1;
               end
            end
            S_WINDUP: begin
               if (cnt_q == '0) begin
                  state_d = S_STRIKE;
                  cnt_d   = ST_M1;
                  flag_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            S_STRIKE: begin
               flag_d = blk_now;
               if (cnt_q == '0) begin
                  state_d = S_COOLDOWN;
                  if (blk_now) begin
                     blocked_d = 1'b1;
                     cnt_d     = is_heavy ? HC2_M1 : LC2_M1;
                  end else begin
                     hit_d       = 1'b1;
                     damage_d    = atk_dmg;
                     dmg_total_d = dmg_sum[16] ? 16'hFFFF : dmg_sum[15:0];
                     cnt_d       = is_heavy ? HC_M1 : LC_M1;
                  end
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               if (cnt_q == '0) begin
                  state_d    = S_IDLE;
                  atk_type_d = 2'b00;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs with synchronous active-high reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         flag_q      <= 1'b0;
         atk_type_q  <= 2'b00;
         busy_q      <= 1'b0;
         hit_q       <= 1'b0;
         blocked_q   <= 1'b0;
         damage_q    <= 8'd0;
         dmg_total_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         flag_q      <= flag_d;
         atk_type_q  <= atk_type_d;
         busy_q      <= busy_d;
         hit_q       <= hit_d;
         blocked_q   <= blocked_d;
         damage_q    <= damage_d;
         dmg_total_q <= dmg_total_d;
      end
   end

   assign bus.o_state     = state_q;
   assign bus.o_atk_type  = atk_type_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_hit       = hit_q;
   assign bus.o_blocked   = blocked_q;
   assign bus.o_damage    = damage_q;
   assign bus.o_dmg_total = dmg_total_q;

endmodule
